// File: rtl/msg_inbox_pkg.sv
// msg_inbox_pkg: shared types and constants for the message inbox.
package msg_inbox_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'b00,
        SLOT_FILLING = 2'b01,
        SLOT_READY   = 2'b10
    } slot_state_e;

    localparam logic [4:0]  TERM_WORD_IDX  = 5'd31;
    localparam logic [31:0] TERM_DATA      = 32'h1;
    localparam int unsigned WORDS_PER_SLOT = 32;

endpackage

// File: rtl/msg_inbox_ram.sv
// msg_inbox_ram: simple dual-port message buffer, one write port and one
// registered read-first read port. The read register holds its value
// between reads.
module msg_inbox_ram
    import msg_inbox_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 32,
    parameter int unsigned ADDR_W    = $clog2(NUM_SLOTS * WORDS_PER_SLOT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [NUM_SLOTS * WORDS_PER_SLOT];
    logic [31:0] rd_data_q, rd_data_d;

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data sampled from the pre-edge array contents (read-first), held otherwise.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/msg_inbox.sv
// msg_inbox: receive endpoint for the descriptor engine word stream.
// Word writes land in a slot-organised buffer; a word-31 write of 1 closes a
// slot, which is queued in arrival order for the consumer to read and release.
// Optional per-slot length counters: define MSG_INBOX_LEN_COUNT_EN.
module msg_inbox
    import msg_inbox_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 32,
    parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [9:0]           in_addr,
    input  logic [31:0]          in_data,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic                 err_drop,
    output logic                 rd_slot_valid,
    output logic [SLOT_W-1:0]    rd_slot_idx,
    output logic [5:0]           rd_slot_len,
    input  logic                 rd_en,
    input  logic [4:0]           rd_word,
    output logic [31:0]          rd_data,
    output logic                 rd_data_valid,
    input  logic                 rd_release
);

    localparam int unsigned CNT_W = SLOT_W + 1;

    logic [SLOT_W-1:0] wr_slot;
    logic [4:0]        wr_word;
    logic              wr_hit_ready;
    logic              wr_accept;
    logic              wr_term;
    logic              fifo_empty;
    logic              do_pop;
    logic [SLOT_W-1:0] head;

    slot_state_e          state_q [NUM_SLOTS];
    slot_state_e          state_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] busy_q, busy_d;

    logic [SLOT_W-1:0] fifo_q [NUM_SLOTS];
    logic [SLOT_W-1:0] fifo_d [NUM_SLOTS];
    logic [SLOT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SLOT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic err_drop_q, err_drop_d;
    logic rd_valid_q, rd_valid_d;

    assign wr_slot      = in_addr[5 +: SLOT_W];
    assign wr_word      = in_addr[4:0];
    assign wr_hit_ready = in_valid && (state_q[wr_slot] == SLOT_READY);
    assign wr_accept    = in_valid && !wr_hit_ready;
    assign wr_term      = wr_accept && (wr_word == TERM_WORD_IDX) && (in_data == TERM_DATA);
    assign fifo_empty   = (cnt_q == '0);
    assign do_pop       = rd_release && !fifo_empty;
    assign head         = fifo_q[rd_ptr_q];

    // Per-slot lifecycle. The released head is READY, so any write to it this
    // cycle was dropped and cannot collide with the release.
    always_comb begin
        state_d = state_q;
        busy_d  = '0;
        if (wr_accept && (state_q[wr_slot] == SLOT_FREE)) begin
            state_d[wr_slot] = SLOT_FILLING;
        end
        if (wr_term) begin
            state_d[wr_slot] = SLOT_READY;
        end
        if (do_pop) begin
            state_d[head] = SLOT_FREE;
        end
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            busy_d[i] = (state_d[i] == SLOT_READY);
        end
    end

    // Slot state and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= SLOT_FREE;
            end
            busy_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Ready queue of completed slots; depth equals slot count so it never overflows.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_term) begin
            fifo_d[wr_ptr_q] = wr_slot;
            wr_ptr_d         = wr_ptr_q + SLOT_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + SLOT_W'(1);
        end
        case ({wr_term, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Ready queue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Sticky drop flag and one-cycle read strobe.
    always_comb begin
        err_drop_d = err_drop_q || wr_hit_ready;
        rd_valid_d = rd_en;
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_drop_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            err_drop_q <= err_drop_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef MSG_INBOX_LEN_COUNT_EN
    logic [5:0] len_q [NUM_SLOTS];
    logic [5:0] len_d [NUM_SLOTS];

    // Per-slot data-word counters, saturating at 31, cleared on release.
    always_comb begin
        len_d = len_q;
        if (wr_accept && (wr_word != TERM_WORD_IDX) && (len_q[wr_slot] < 6'd31)) begin
            len_d[wr_slot] = len_q[wr_slot] + 6'd1;
        end
        if (do_pop) begin
            len_d[head] = '0;
        end
    end

    // Length counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            len_q <= len_d;
        end
    end

    assign rd_slot_len = len_q[head];
`else
    assign rd_slot_len = '0;
`endif

    msg_inbox_ram #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_addr ({wr_slot, wr_word}),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr ({head, rd_word}),
        .rd_data (rd_data)
    );

    assign slot_busy     = busy_q;
    assign err_drop      = err_drop_q;
    assign rd_slot_valid = !fifo_empty;
    assign rd_slot_idx   = head;
    assign rd_data_valid = rd_valid_q;

endmodule
